shading_pixel_writer: RTL

Downstream consumer of the shading stage. Each shaded RGB result is accepted in Q16.16 fixed-point (nominally [0,1)) and quantised to 8 bits per channel. The block packs the result into a 32-bit framebuffer word and tags it with a raster word address. Words are buffered in a small FIFO and handed to the memory write port over a valid/ready handshake; a pulse marks completion of each frame.

---
 rtl/shading_pixel_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/shading_pixel_writer.sv
// shading_pixel_writer
//   Packs shaded RGB results (Q16.16, nominally [0,1)) into 32-bit framebuffer
//   words {8'h00, R8, G8, B8}, tags each with its raster word address and
//   queues it in a small FIFO feeding a valid/ready memory write port.
//
// Ports
//   i_clk, i_rstn    : clock (rising edge) / asynchronous active-low reset
//   i_clr            : synchronous raster restart (pixel index -> 0)
//   i_valid, i_light : shading result and its valid; [0]=R [1]=G [2]=B
//   o_busy           : FIFO full, input is ignored while high
//   o_wr_valid/addr/data, i_wr_ready : memory write handshake
//   o_frame_done     : one-cycle pulse after the final pixel of a frame pops
module shading_pixel_writer #(
  parameter int                WIDTH     = 640,
  parameter int                HEIGHT    = 480,
  parameter int                LEN_A     = 32,
  parameter logic [LEN_A-1:0]  BASE_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic signed [2:0][31:0] i_light,
  output logic                    o_busy,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [LEN_A-1:0]        o_wr_addr,
  output logic [31:0]             o_wr_data,
  output logic                    o_frame_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);

  typedef struct packed {
    logic [LEN_A-1:0] addr;
    logic [31:0]      data;
    logic             last;
  } entry_t;

  // Saturating Q16.16 -> 8-bit: negative -> 0, >=1.0 -> FF, else truncate.
  // Bits [7:0] never influence the result, so they are not passed in.
  function automatic logic [7:0] quant(input logic [31:8] v);
    logic [7:0] r;
    r = v[15:8];
    if (v[31])          r = 8'h00;
    else if (|v[30:16]) r = 8'hFF;
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  entry_t           mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [LEN_A-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             full, empty, push, pop;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic [LEN_A-1:0] cur_idx;
  entry_t           wr_entry, head;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push  = i_valid && !full;
  assign pop   = !empty && i_wr_ready;

  // ------------------------------------------------------ raster position
  // i_clr takes effect before this cycle's push, so a coinciding push lands
  // on index 0 and the counters leave pointing at index 1.
  always_comb begin
    cur_x   = i_clr ? '0 : x_q;
    cur_y   = i_clr ? '0 : y_q;
    cur_idx = i_clr ? '0 : idx_q;
    x_d     = cur_x;
    y_d     = cur_y;
    idx_d   = cur_idx;
    if (push) begin
      if (cur_x == XLAST) begin
        x_d = '0;
        if (cur_y == YLAST) begin
          y_d   = '0;
          idx_d = '0;
        end else begin
          y_d   = cur_y + 1'b1;
          idx_d = cur_idx + 1'b1;
        end
      end else begin
        x_d   = cur_x + 1'b1;
        idx_d = cur_idx + 1'b1;
      end
    end
  end

  // The linear index rides alongside x/y so the address needs only an adder.
  always_comb begin
    wr_entry.addr = BASE_ADDR + cur_idx;
    wr_entry.data = {8'h00, quant(i_light[0][31:8]), quant(i_light[1][31:8]),
                     quant(i_light[2][31:8])};
    wr_entry.last = (cur_x == XLAST) && (cur_y == YLAST);
  end

  // ------------------------------------------------------------ FIFO ctl
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  assign head   = mem_q[rd_ptr_q[PW-1:0]];
  // Pulse follows the pop of a last-tagged entry, independent of push time.
  assign done_d = pop && head.last;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      // Storage is cleared so the head outputs read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      if (push) mem_q[wr_ptr_q[PW-1:0]] <= wr_entry;
    end
  end

  // ------------------------------------------------------------- outputs
  // Head word is read straight from the storage flops: it only changes when
  // the read pointer moves, so it holds steady under backpressure, and a
  // word written this cycle is first visible next cycle.
  assign o_busy       = full;
  assign o_wr_valid   = !empty;
  assign o_wr_addr    = head.addr;
  assign o_wr_data    = head.data;
  assign o_frame_done = done_q;

endmodule
